// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer that time-shares one single-port RAM
// between two requesters, with registered grant and read-data-valid pulses.
module ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t                  state;
  state_t                  state_next;
  logic                    owner;       // 0 = A, 1 = B
  logic                    ptr;         // side favoured on a tie: 0 = A, 1 = B
  logic                    sel_valid;
  logic                    sel;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  // Requests are only looked at in IDLE; elsewhere sel_valid stays low.
  always_comb begin
    sel_valid  = 1'b0;
    sel        = 1'b0;
    state_next = state;
    if (state == IDLE) begin
      if (a_req && b_req) begin
        sel_valid = 1'b1;
        sel       = ptr;
      end else if (a_req) begin
        sel_valid = 1'b1;
        sel       = 1'b0;
      end else if (b_req) begin
        sel_valid = 1'b1;
        sel       = 1'b1;
      end
    end
    sel_we    = sel ? b_we    : a_we;
    sel_addr  = sel ? b_addr  : a_addr;
    sel_wdata = sel ? b_wdata : a_wdata;
    case (state)
      IDLE:    if (sel_valid) state_next = sel_we ? WRITE : READ;
      WRITE:   state_next = IDLE;
      READ:    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      ptr      <= 1'b0;
      busy     <= 1'b0;
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
      ram_data <= '0;
      ram_addr <= '0;
      ram_we   <= 1'b0;
    end else begin
      state    <= state_next;
      busy     <= (state_next != IDLE);
      a_gnt    <= sel_valid && !sel;
      b_gnt    <= sel_valid &&  sel;
      ram_we   <= sel_valid && sel_we;
      if (sel_valid) begin
        owner    <= sel;
        ptr      <= ~sel;
        ram_addr <= sel_addr;
        ram_data <= sel_wdata;
      end
      // In RESP the RAM output reflects the address presented during READ.
      a_rvalid <= (state == RESP) && !owner;
      b_rvalid <= (state == RESP) &&  owner;
      if (state == RESP && !owner) a_rdata <= ram_q;
      if (state == RESP &&  owner) b_rdata <= ram_q;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural 8x64 single-port RAM.
module tb_ram_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       a_req = 1'b0, a_we = 1'b0;
  logic [5:0] a_addr = '0;
  logic [7:0] a_wdata = '0;
  logic       b_req = 1'b0, b_we = 1'b0;
  logic [5:0] b_addr = '0;
  logic [7:0] b_wdata = '0;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid, ram_we, busy;
  logic [7:0] a_rdata, b_rdata, ram_data, ram_q;
  logic [5:0] ram_addr;

  ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_q(ram_q), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0] mem [0:63];
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic       side;
    logic       we;
    logic [5:0] addr;
    logic [7:0] data;
  } gnt_t;

  gnt_t       exp_gnt[$];
  logic [7:0] exp_rd_a[$];
  logic [7:0] exp_rd_b[$];
  int         rd_gnt_cyc[2];
  int         rv_cyc[2];

  task automatic expect_gnt(input logic side, input logic we, input logic [5:0] addr, input logic [7:0] data);
    gnt_t g;
    g.side = side; g.we = we; g.addr = addr; g.data = data;
    exp_gnt.push_back(g);
  endtask

  task automatic expect_rd(input logic side, input logic [7:0] data);
    if (side) exp_rd_b.push_back(data);
    else      exp_rd_a.push_back(data);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a grant or read data.
  always @(negedge clock) begin
    gnt_t       g;
    logic [7:0] d;
    if (a_gnt || b_gnt) begin
      check("gnt_exclusive", {31'b0, a_gnt && b_gnt}, 32'd0);
      if (exp_gnt.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_gnt: got a_gnt=%0d b_gnt=%0d expected none", a_gnt, b_gnt);
      end else begin
        g = exp_gnt.pop_front();
        check("gnt_side", {31'b0, b_gnt}, {31'b0, g.side});
        check("gnt_ram_we", {31'b0, ram_we}, {31'b0, g.we});
        check("gnt_ram_addr", {26'b0, ram_addr}, {26'b0, g.addr});
        if (g.we) check("gnt_ram_data", {24'b0, ram_data}, {24'b0, g.data});
        else rd_gnt_cyc[g.side] = cyc;
      end
    end
    if (a_rvalid || b_rvalid) begin
      check("rvalid_exclusive", {31'b0, a_rvalid && b_rvalid}, 32'd0);
      if (a_rvalid) begin
        if (exp_rd_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_a_rvalid: got 1 expected 0, a_rdata=0x%0h", a_rdata);
        end else begin
          d = exp_rd_a.pop_front();
          check("a_rdata", {24'b0, a_rdata}, {24'b0, d});
          check("a_read_latency", cyc - rd_gnt_cyc[0], 32'd2);
          rv_cyc[0] = cyc;
        end
      end
      if (b_rvalid) begin
        if (exp_rd_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_b_rvalid: got 1 expected 0, b_rdata=0x%0h", b_rdata);
        end else begin
          d = exp_rd_b.pop_front();
          check("b_rdata", {24'b0, b_rdata}, {24'b0, d});
          check("b_read_latency", cyc - rd_gnt_cyc[1], 32'd2);
          rv_cyc[1] = cyc;
        end
      end
    end
  end

  // One requester transaction: hold the request until the grant appears.
  task automatic txn(input logic side, input logic we, input logic [5:0] addr, input logic [7:0] data);
    logic got;
    got = 1'b0;
    if (side) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = data; end
    else      begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = data; end
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clock); #1;
      got = side ? b_gnt : a_gnt;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL gnt_timeout side=%0d: got no grant expected one", side);
    end
    if (side) b_req = 1'b0;
    else      a_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (exp_gnt.size() + exp_rd_a.size() + exp_rd_b.size()) > 0; i++)
      @(posedge clock);
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_a_gnt", {31'b0, a_gnt}, 32'd0);
    check("rst_b_gnt", {31'b0, b_gnt}, 32'd0);
    check("rst_a_rvalid", {31'b0, a_rvalid}, 32'd0);
    check("rst_b_rvalid", {31'b0, b_rvalid}, 32'd0);
    check("rst_ram_we", {31'b0, ram_we}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_a_rdata", {24'b0, a_rdata}, 32'd0);
    check("rst_b_rdata", {24'b0, b_rdata}, 32'd0);
    check("rst_ram_data", {24'b0, ram_data}, 32'd0);
    check("rst_ram_addr", {26'b0, ram_addr}, 32'd0);
    reset = 1'b0;

    // A writes 0x11@3, then B reads it back.
    expect_gnt(1'b0, 1'b1, 6'd3, 8'h11);
    txn(1'b0, 1'b1, 6'd3, 8'h11);
    check("write_busy", {31'b0, busy}, 32'd1);
    drain();
    expect_gnt(1'b1, 1'b0, 6'd3, 8'h00);
    expect_rd(1'b1, 8'h11);
    txn(1'b1, 1'b0, 6'd3, 8'h00);
    drain();

    // Both requesting continuously: strict alternation starting with A.
    for (int i = 0; i < 3; i++) begin
      expect_gnt(1'b0, 1'b1, 6'(i), 8'hA0 + 8'(i));
      expect_gnt(1'b1, 1'b1, 6'd32 + 6'(i), 8'hB0 + 8'(i));
    end
    fork
      for (int i = 0; i < 3; i++) txn(1'b0, 1'b1, 6'(i), 8'hA0 + 8'(i));
      for (int j = 0; j < 3; j++) txn(1'b1, 1'b1, 6'd32 + 6'(j), 8'hB0 + 8'(j));
    join
    drain();
    for (int i = 0; i < 3; i++) begin
      expect_gnt(1'b0, 1'b0, 6'(i), 8'h00);
      expect_rd(1'b0, 8'hA0 + 8'(i));
      txn(1'b0, 1'b0, 6'(i), 8'h00);
    end
    for (int i = 0; i < 3; i++) begin
      expect_gnt(1'b1, 1'b0, 6'd32 + 6'(i), 8'h00);
      expect_rd(1'b1, 8'hB0 + 8'(i));
      txn(1'b1, 1'b0, 6'd32 + 6'(i), 8'h00);
    end
    drain();

    // B fills @0/@1 (pointer ends on A), then simultaneous reads.
    expect_gnt(1'b1, 1'b1, 6'd0, 8'h01);
    txn(1'b1, 1'b1, 6'd0, 8'h01);
    expect_gnt(1'b1, 1'b1, 6'd1, 8'h02);
    txn(1'b1, 1'b1, 6'd1, 8'h02);
    drain();
    expect_gnt(1'b0, 1'b0, 6'd0, 8'h00);
    expect_gnt(1'b1, 1'b0, 6'd1, 8'h00);
    expect_rd(1'b0, 8'h01);
    expect_rd(1'b1, 8'h02);
    fork
      txn(1'b0, 1'b0, 6'd0, 8'h00);
      txn(1'b1, 1'b0, 6'd1, 8'h00);
    join
    drain();
    check("rvalid_spacing", rv_cyc[1] - rv_cyc[0], 32'd3);

    // Overwrite then read back.
    expect_gnt(1'b0, 1'b1, 6'd2, 8'h03);
    txn(1'b0, 1'b1, 6'd2, 8'h03);
    expect_gnt(1'b0, 1'b1, 6'd2, 8'hAA);
    txn(1'b0, 1'b1, 6'd2, 8'hAA);
    expect_gnt(1'b0, 1'b0, 6'd2, 8'h00);
    expect_rd(1'b0, 8'hAA);
    txn(1'b0, 1'b0, 6'd2, 8'h00);
    drain();

    // Reset while B's read is in READ: no rvalid, pointer back to A.
    expect_gnt(1'b1, 1'b0, 6'd5, 8'h00);
    txn(1'b1, 1'b0, 6'd5, 8'h00);
    reset = 1'b1;
    @(posedge clock); #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_b_rvalid", {31'b0, b_rvalid}, 32'd0);
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("midrst_b_rdata_hold", {24'b0, b_rdata}, 32'd0);
    expect_gnt(1'b0, 1'b1, 6'd6, 8'h55);
    expect_gnt(1'b1, 1'b1, 6'd7, 8'h66);
    fork
      txn(1'b0, 1'b1, 6'd6, 8'h55);
      txn(1'b1, 1'b1, 6'd7, 8'h66);
    join
    drain();

    check("leftover_gnt", exp_gnt.size(), 32'd0);
    check("leftover_rd", exp_rd_a.size() + exp_rd_b.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
